// File: rtl/alu_sched_if.sv
// Request, shared-ALU and response signals of the two-requester ALU scheduler.
// The slave modport is the controller side and the master modport is the environment side.
interface alu_sched_if;
  logic       req0_valid;
  logic [1:0] req0_oper;
  logic [3:0] req0_in1;
  logic [3:0] req0_in2;
  logic       req0_ready;
  logic       req1_valid;
  logic [1:0] req1_oper;
  logic [3:0] req1_in1;
  logic [3:0] req1_in2;
  logic       req1_ready;
  logic [1:0] alu_oper;
  logic [3:0] alu_in1;
  logic [3:0] alu_in2;
  logic [4:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [4:0] rsp_out;
  logic       rsp_dz;

  modport slave (
    input  req0_valid, req0_oper, req0_in1, req0_in2,
    input  req1_valid, req1_oper, req1_in1, req1_in2,
    input  alu_out, rsp_ready,
    output req0_ready, req1_ready,
    output alu_oper, alu_in1, alu_in2,
    output rsp_valid, rsp_id, rsp_out, rsp_dz
  );

  modport master (
    output req0_valid, req0_oper, req0_in1, req0_in2,
    output req1_valid, req1_oper, req1_in1, req1_in2,
    output alu_out, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_oper, alu_in1, alu_in2,
    input  rsp_valid, rsp_id, rsp_out, rsp_dz
  );
endinterface

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one external ALU between two requesters.
// Runs one operation at a time: grant, wait SETTLE cycles, then hold the response.
module alu_sched #(
  parameter int unsigned SETTLE = 2
) (
  input logic        clk,
  input logic        rst,
  alu_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic       prio_q, prio_d;
  logic [3:0] cnt_q, cnt_d;
  logic       id_q, id_d;
  logic [1:0] oper_q, oper_d;
  logic [3:0] in1_q, in1_d;
  logic [3:0] in2_q, in2_d;
  logic       rsp_id_q, rsp_id_d;
  logic [4:0] rsp_out_q, rsp_out_d;
  logic       rsp_dz_q, rsp_dz_d;

  logic       grant;
  logic       gnt_id;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    oper_d    = oper_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    rsp_id_d  = rsp_id_q;
    rsp_out_d = rsp_out_q;
    rsp_dz_d  = rsp_dz_q;
    grant     = 1'b0;
    // With both pending the pointer decides; otherwise the only pending one wins.
    gnt_id    = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;

    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          grant   = 1'b1;
          id_d    = gnt_id;
          prio_d  = ~gnt_id;
          oper_d  = gnt_id ? bus.req1_oper : bus.req0_oper;
          in1_d   = gnt_id ? bus.req1_in1  : bus.req0_in1;
          in2_d   = gnt_id ? bus.req1_in2  : bus.req0_in2;
          cnt_d   = 4'd0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          rsp_id_d  = id_q;
          rsp_out_d = bus.alu_out;
          rsp_dz_d  = (oper_q == 2'b11) && (in2_q == 4'd0);
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      cnt_q     <= 4'd0;
      id_q      <= 1'b0;
      oper_q    <= 2'd0;
      in1_q     <= 4'd0;
      in2_q     <= 4'd0;
      rsp_id_q  <= 1'b0;
      rsp_out_q <= 5'd0;
      rsp_dz_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      oper_q    <= oper_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      rsp_id_q  <= rsp_id_d;
      rsp_out_q <= rsp_out_d;
      rsp_dz_q  <= rsp_dz_d;
    end
  end

  // Latched operands only change at a grant, so they double as the held ALU drive.
  assign bus.alu_oper   = oper_q;
  assign bus.alu_in1    = in1_q;
  assign bus.alu_in2    = in2_q;

  assign bus.req0_ready = grant && !gnt_id && !rst;
  assign bus.req1_ready = grant &&  gnt_id && !rst;

  assign bus.rsp_valid  = (state_q == RESP) && !rst;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_out    = rsp_out_q;
  assign bus.rsp_dz     = rsp_dz_q;

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter: SETTLE, default 2, ALU settle cycles the controller waits before capturing alu_out (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_oper / req0_in1 / req0_in2  input  2/4/4  requester 0 opcode and operands.
REQ-006 req0_ready  output  1  requester 0 accepted this cycle.
REQ-007 req1_valid, req1_oper, req1_in1, req1_in2, req1_ready: same widths and meaning as requester 0.
REQ-008 alu_oper / alu_in1 / alu_in2  output  2/4/4  drive to the shared ALU.
REQ-009 alu_out  input  5  ALU result.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumer accepts.
REQ-012 rsp_id  output  1  index of requester that owns the response.
REQ-013 rsp_out  output  5  captured ALU result.
REQ-014 rsp_dz  output  1  divide-by-zero flag (oper=2'b11 and in2=0).

Function
REQ-015 FSM states: IDLE, EXEC, RESP; one operation in flight at a time.
REQ-016 IDLE: if any reqN_valid, grant one requester, latch its oper/in1/in2 and id, load counter to 0, go EXEC next cycle.
REQ-017 reqN_ready is combinational: 1 only in IDLE, for the granted requester, in the grant cycle; 0 otherwise.
REQ-018 Arbitration: round-robin pointer prio (1 bit); both valid -> grant prio; one valid -> grant it; after every grant prio = ~granted id.
REQ-019 EXEC: alu_oper/alu_in1/alu_in2 equal latched values; counter increments each cycle; at counter==SETTLE-1 capture alu_out into rsp_out, compute rsp_dz from latched oper/in2, go RESP.
REQ-020 Outside EXEC, alu_* outputs hold their last driven values (0 after reset).
REQ-021 RESP: rsp_valid=1; rsp_id, rsp_out, rsp_dz stable until rsp_valid&rsp_ready; that cycle go IDLE.
REQ-022 Latency: handshake in cycle T -> rsp_valid first high in cycle T+SETTLE+1; with rsp_ready held high, next grant earliest in cycle T+SETTLE+2 (one-op throughput per SETTLE+2 cycles).
REQ-023 No grants while in EXEC or RESP; requests wait, valid held by requester, no loss.
REQ-024 rsp_dz=1 iff latched oper==2'b11 and latched in2==0; rsp_out is captured as is (ALU yields 0).
REQ-025 Arithmetic is done solely by the external ALU; controller performs no result widening/truncation (5-bit pass-through).
REQ-026 reqN_valid dropping while waiting has no effect; reqN_valid in EXEC/RESP is ignored.

Reset
REQ-027 rst high at a rising edge: state=IDLE, prio=0, counter=0, latched id/operands=0, alu_*=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_dz=0.
REQ-028 Reset wins over every event in the same cycle, including mid-EXEC and mid-RESP; the in-flight operation is discarded, no response issued.
REQ-029 First cycle after reset release behaves as IDLE; pending requests are granted per REQ-018 with prio=0.

Verification
REQ-030 Reset: rst=1 for 2 cycles with both valids high -> all outputs 0, req0_ready=req1_ready=0 during reset.
REQ-031 Single op, SETTLE=2: req0 oper=00, in1=7, in2=5 accepted cycle T -> alu_* = 00/7/5 in T+1..T+2, rsp_valid=1 at T+3, rsp_out=12, rsp_id=0, rsp_dz=0.
REQ-032 Contention: both valid after reset, req1 oper=01 in1=3 in2=4 -> req0 granted first, then req1; responses rsp_id 0 then 1, second rsp_out=12; prio=0 again after.
REQ-033 Backpressure: rsp_ready=0 for 4 cycles in RESP -> rsp_valid/id/out/dz stable, req*_ready=0, alu_* unchanged; release -> IDLE next cycle.
REQ-034 Divide-by-zero: oper=11, in1=9, in2=0 -> rsp_out=0, rsp_dz=1; oper=11, in1=9, in2=2 -> rsp_out=4, rsp_dz=0.
REQ-035 Mid-op reset: rst=1 in second EXEC cycle -> no rsp_valid, prio=0; held req0 re-granted in first cycle after release.
